key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter NUM_KEYS, default 3, number of independent key channels (mode button, pause, power).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable samples required to accept a level change.
REQ-003 Parameter LONG_CYCLES, default 200_000_000, held cycles before a long-press event.
REQ-004 Parameter rule: LONG_CYCLES > DEBOUNCE_CYCLES >= 2; other values are illegal and need not be supported.
REQ-005 clk  input  1  system clock, single clock domain for all logic.
REQ-006 reset  input  1  reset, synchronous and active-high.
REQ-007 key_in  input  NUM_KEYS  raw asynchronous push-button levels, 1 = pressed.
REQ-008 key_level  output  NUM_KEYS  debounced key state, 1 = pressed.
REQ-009 key_press  output  NUM_KEYS  one-cycle pulse on an accepted press.
REQ-010 key_release  output  NUM_KEYS  one-cycle pulse on an accepted release.
REQ-011 key_long  output  NUM_KEYS  one-cycle pulse when a press has been held LONG_CYCLES cycles.

Function
REQ-012 Each key_in bit SHALL pass through a two-flop synchronizer; all further logic SHALL use only the synchronized bit (sync).
REQ-013 Each channel SHALL run a four-state FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-014 IDLE: sync=1 -> PRESS_WAIT with debounce counter = 1; otherwise stay and hold counter at 0.
REQ-015 PRESS_WAIT: sync=0 -> IDLE with counter cleared; sync=1 increments counter; counter reaching DEBOUNCE_CYCLES -> HELD.
REQ-016 The HELD entry cycle SHALL assert key_press for exactly one cycle and set key_level to 1 in the same cycle.
REQ-017 Latency from the first clk edge sampling key_in=1 (stable) to key_press high SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-018 HELD: hold counter increments each cycle in HELD or RELEASE_WAIT, saturating at LONG_CYCLES; the increment that reaches LONG_CYCLES SHALL pulse key_long for one cycle.
REQ-019 key_long SHALL fire at most once per press; the hold counter clears only on return to IDLE.
REQ-020 HELD: sync=0 -> RELEASE_WAIT with debounce counter = 1.
REQ-021 RELEASE_WAIT: sync=1 -> HELD (glitch rejected, no pulses, hold counter kept); sync=0 increments; reaching DEBOUNCE_CYCLES -> IDLE.
REQ-022 The IDLE entry from RELEASE_WAIT SHALL pulse key_release for one cycle and clear key_level in the same cycle.
REQ-023 key_level SHALL be 1 exactly in HELD and RELEASE_WAIT.
REQ-024 If the long threshold is reached in the same cycle as the release is accepted, key_long and key_release SHALL both pulse in that cycle.
REQ-025 Channels SHALL be fully independent; simultaneous presses on several keys SHALL produce simultaneous pulses.
REQ-026 Bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no output change.
REQ-027 Counter widths SHALL be $clog2(LONG_CYCLES+1) bits; counters never wrap.

Reset
REQ-028 While reset=1 at a clk edge: FSM -> IDLE; counters and synchronizer flops -> 0; key_level, key_press, key_release and key_long -> 0.
REQ-029 Reset asserted mid-press SHALL discard the press with no release pulse; a key still held after reset SHALL be re-accepted through full debounce.

Structure
REQ-030 The shared washer package SHALL hold the FSM state encoding plus board constants (DEBOUNCE 1_000_000, LONG 200_000_000) and simulation constants (DEBOUNCE 4, LONG 16).
REQ-031 One sub-module key_channel (one key: synchronizer, FSM, counters) SHALL be instantiated NUM_KEYS times by a generate loop.
REQ-032 All outputs SHALL be registered.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-033 Clean press: key_in[0] 0->1 and held -> key_press[0] pulses 6 cycles after the first sampling edge; key_level[0]=1 from that cycle.
REQ-034 Bounce: key_in[1] toggles 1,0,1,0 every cycle, then stays 0 -> all outputs stay 0.
REQ-035 Release glitch: key held 8 cycles, 2-cycle low glitch, then high again -> no key_release, key_level stays 1.
REQ-036 Long press: key held 30 cycles -> exactly one key_long pulse 16 cycles after key_press; one key_release after letting go.
REQ-037 Simultaneous: key_in=3'b101 at the same edge -> key_press=3'b101 in a single cycle.
REQ-038 Reset mid-hold: reset pulse while key_level[2]=1 and key still held -> outputs 0, no key_release; key_press[2] again 6 cycles after reset deasserts.

Source files
------------

// File: rtl/key_conditioner_pkg.sv
// Shared washer key-handling package: per-key FSM encoding plus the board
// and simulation timing constants used to size the key conditioner.
package key_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned NUM_KEYS_DEFAULT      = 32'd3;

  localparam int unsigned BOARD_DEBOUNCE_CYCLES = 32'd1_000_000;
  localparam int unsigned BOARD_LONG_CYCLES     = 32'd200_000_000;

  localparam int unsigned SIM_DEBOUNCE_CYCLES   = 32'd4;
  localparam int unsigned SIM_LONG_CYCLES       = 32'd16;

  // Both counters share one width so that neither can ever wrap before LONG.
  function automatic int unsigned cnt_width(input int unsigned long_cycles);
    return $clog2(long_cycles + 32'd1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchronizer, debounce / hold FSM and its counters,
// with every output driven straight from a flop.
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = BOARD_LONG_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned CW = cnt_width(LONG_CYCLES);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LONG_HIT = CW'(LONG_CYCLES - 32'd1);

  logic          sync_meta_r;
  logic          sync_r;
  key_state_e    state_r;
  logic [CW-1:0] deb_cnt_r;
  logic [CW-1:0] hold_cnt_r;
  logic          hold_active_s;
  logic          hold_hit_s;

  // Two-flop synchronizer for the raw asynchronous button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= key_in;
      sync_r      <= sync_meta_r;
    end
  end

  // Hold counter advances in HELD and RELEASE_WAIT until it saturates at LONG.
  always_comb begin
    hold_active_s = 1'b0;
    hold_hit_s    = 1'b0;
    if ((state_r == ST_HELD) || (state_r == ST_RELEASE_WAIT)) begin
      hold_active_s = (hold_cnt_r != LONG_MAX);
      hold_hit_s    = (hold_cnt_r == LONG_HIT);
    end else begin
      hold_active_s = 1'b0;
      hold_hit_s    = 1'b0;
    end
  end

  // Debounce / hold FSM with registered level and event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      deb_cnt_r   <= CNT_ZERO;
      hold_cnt_r  <= CNT_ZERO;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= hold_hit_s;
      if (hold_active_s) begin
        hold_cnt_r <= hold_cnt_r + CNT_ONE;
      end

      case (state_r)
        ST_IDLE: begin
          hold_cnt_r <= CNT_ZERO;
          if (sync_r) begin
            state_r   <= ST_PRESS_WAIT;
            deb_cnt_r <= CNT_ONE;
          end else begin
            deb_cnt_r <= CNT_ZERO;
          end
        end

        ST_PRESS_WAIT: begin
          if (!sync_r) begin
            state_r   <= ST_IDLE;
            deb_cnt_r <= CNT_ZERO;
          end else if (deb_cnt_r == DEB_MAX) begin
            state_r   <= ST_HELD;
            deb_cnt_r <= CNT_ZERO;
            key_press <= 1'b1;
            key_level <= 1'b1;
          end else begin
            deb_cnt_r <= deb_cnt_r + CNT_ONE;
          end
        end

        ST_HELD: begin
          key_level <= 1'b1;
          if (!sync_r) begin
            state_r   <= ST_RELEASE_WAIT;
            deb_cnt_r <= CNT_ONE;
          end else begin
            deb_cnt_r <= CNT_ZERO;
          end
        end

        ST_RELEASE_WAIT: begin
          // A short low glitch returns to HELD silently; hold count is kept.
          if (sync_r) begin
            state_r   <= ST_HELD;
            deb_cnt_r <= CNT_ZERO;
          end else if (deb_cnt_r == DEB_MAX) begin
            state_r     <= ST_IDLE;
            deb_cnt_r   <= CNT_ZERO;
            hold_cnt_r  <= CNT_ZERO;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else begin
            deb_cnt_r <= deb_cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          deb_cnt_r  <= CNT_ZERO;
          hold_cnt_r <= CNT_ZERO;
          key_level  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Washer front-panel key conditioner: NUM_KEYS independent debounced
// channels, each reporting level, press, release and long-press events.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = NUM_KEYS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = BOARD_LONG_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_channel (
      .clk         (clk),
      .reset       (reset),
      .key_in      (key_in[k]),
      .key_level   (key_level[k]),
      .key_press   (key_press[k]),
      .key_release (key_release[k]),
      .key_long    (key_long[k])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE=4, LONG=16; expected
// values are hand-derived cycle counts from the first sampling edge.
module tb_key_conditioner;
  import key_conditioner_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] key_in;
  logic [2:0] key_level;
  logic [2:0] key_press;
  logic [2:0] key_release;
  logic [2:0] key_long;

  int n_assert;
  int n_fail;
  int press_n [3];
  int rel_n   [3];
  int long_n  [3];

  key_conditioner #(
    .NUM_KEYS        (3),
    .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
    .LONG_CYCLES     (SIM_LONG_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      press_n[i] += int'(key_press[i]);
      rel_n[i]   += int'(key_release[i]);
      long_n[i]  += int'(key_long[i]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] lvl, input logic [2:0] prs,
                            input logic [2:0] rel, input logic [2:0] lng);
    check({tag, ".level"},   32'(key_level),   32'(lvl));
    check({tag, ".press"},   32'(key_press),   32'(prs));
    check({tag, ".release"}, 32'(key_release), 32'(rel));
    check({tag, ".long"},    32'(key_long),    32'(lng));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    key_in   = 3'b000;
    tick(3);
    check_outs("reset_active", 3'b000, 3'b000, 3'b000, 3'b000);
    reset = 1'b0;
    tick(2);
    check_outs("reset_idle", 3'b000, 3'b000, 3'b000, 3'b000);

    // Clean press and prompt release on key 0.
    key_in = 3'b001;
    tick(6);
    check_outs("clean_pre", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);
    check_outs("clean_press", 3'b001, 3'b001, 3'b000, 3'b000);
    tick(1);
    check_outs("clean_held", 3'b001, 3'b000, 3'b000, 3'b000);
    key_in = 3'b000;
    tick(6);
    check_outs("clean_rel_pre", 3'b001, 3'b000, 3'b000, 3'b000);
    tick(1);
    check_outs("clean_release", 3'b000, 3'b000, 3'b001, 3'b000);
    tick(10);

    // Bounce on key 1 shorter than the debounce window.
    key_in = 3'b010; tick(1);
    key_in = 3'b000; tick(1);
    key_in = 3'b010; tick(1);
    key_in = 3'b000;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_outs("bounce", 3'b000, 3'b000, 3'b000, 3'b000);
    end

    // Release glitch on key 0: two low samples must not release.
    key_in = 3'b001;
    tick(7);
    check_outs("glitch_press", 3'b001, 3'b001, 3'b000, 3'b000);
    tick(1);
    key_in = 3'b000;
    tick(2);
    key_in = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_outs("glitch_hold", 3'b001, 3'b000, 3'b000, 3'b000);
    end
    key_in = 3'b000;
    tick(6);
    check_outs("glitch_rel_pre", 3'b001, 3'b000, 3'b000, 3'b000);
    tick(1);
    check_outs("glitch_release", 3'b000, 3'b000, 3'b001, 3'b000);
    tick(10);

    // Long press on key 2: key_long 16 cycles after key_press, only once.
    key_in = 3'b100;
    tick(7);
    check_outs("long_press", 3'b100, 3'b100, 3'b000, 3'b000);
    tick(15);
    check_outs("long_pre", 3'b100, 3'b000, 3'b000, 3'b000);
    tick(1);
    check_outs("long_pulse", 3'b100, 3'b000, 3'b000, 3'b100);
    tick(1);
    check_outs("long_after", 3'b100, 3'b000, 3'b000, 3'b000);
    tick(7);
    key_in = 3'b000;
    tick(6);
    check_outs("long_rel_pre", 3'b100, 3'b000, 3'b000, 3'b000);
    tick(1);
    check_outs("long_release", 3'b000, 3'b000, 3'b100, 3'b000);
    check("long_count_k2", 32'(long_n[2]), 32'd1);
    tick(10);

    // Simultaneous press on keys 0 and 2.
    key_in = 3'b101;
    tick(6);
    check_outs("simul_pre", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);
    check_outs("simul_press", 3'b101, 3'b101, 3'b000, 3'b000);
    key_in = 3'b000;
    tick(7);
    check_outs("simul_release", 3'b000, 3'b000, 3'b101, 3'b000);
    tick(10);

    // Long threshold coincides with accepted release on key 1.
    key_in = 3'b010;
    tick(7);
    check_outs("coinc_press", 3'b010, 3'b010, 3'b000, 3'b000);
    tick(9);
    key_in = 3'b000;
    tick(6);
    check_outs("coinc_pre", 3'b010, 3'b000, 3'b000, 3'b000);
    tick(1);
    check_outs("coinc_both", 3'b000, 3'b000, 3'b010, 3'b010);
    tick(10);

    // Reset mid-hold on key 2, key still held: discard, then re-accept.
    key_in = 3'b100;
    tick(7);
    check_outs("rst_press", 3'b100, 3'b100, 3'b000, 3'b000);
    tick(3);
    reset = 1'b1;
    tick(1);
    check_outs("rst_active", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);
    reset = 1'b0;
    tick(6);
    check_outs("rst_reaccept_pre", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);
    check_outs("rst_reaccept", 3'b100, 3'b100, 3'b000, 3'b000);
    key_in = 3'b000;
    tick(7);
    check_outs("rst_release", 3'b000, 3'b000, 3'b100, 3'b000);
    tick(4);

    // Whole-run pulse totals per key.
    check("total_press_k0", 32'(press_n[0]), 32'd3);
    check("total_press_k1", 32'(press_n[1]), 32'd1);
    check("total_press_k2", 32'(press_n[2]), 32'd4);
    check("total_rel_k0",   32'(rel_n[0]),   32'd3);
    check("total_rel_k1",   32'(rel_n[1]),   32'd1);
    check("total_rel_k2",   32'(rel_n[2]),   32'd3);
    check("total_long_k0",  32'(long_n[0]),  32'd0);
    check("total_long_k1",  32'(long_n[1]),  32'd1);
    check("total_long_k2",  32'(long_n[2]),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
